mmio_responder: RTL and testbench

Memory-mapped I/O responder for the single-cycle processor. It answers the processor's load/store accesses in the 0xF000_0000 I/O window and owns the board I/O:
- drives the output registers for HEX0–3, LEDR and LEDG;
- synchronizes and debounces KEY and SW;
- keeps a sticky key-press register that clears when read.

It sits beside data memory; the top level selects between the two read paths using `ioSel`.

---
 rtl/io_pkg.sv | 41 ++++
 rtl/input_debouncer.sv | 67 ++++++
 rtl/mmio_responder.sv | 112 +++++++++++
 tb/tb_mmio_responder.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_pkg
// Purpose  : I/O window register map and the seven-segment glyph encoder.
// Revision : 1.0
// ============================================================================
package io_pkg;

  localparam logic [31:0] ADDR_HEX     = 32'hF000_0000;
  localparam logic [31:0] ADDR_LEDR    = 32'hF000_0004;
  localparam logic [31:0] ADDR_LEDG    = 32'hF000_0008;
  localparam logic [31:0] ADDR_KEY     = 32'hF000_0010;
  localparam logic [31:0] ADDR_SW      = 32'hF000_0014;
  localparam logic [31:0] ADDR_KEYEDGE = 32'hF000_0018;

  // Active-low segments, bit 6 = g ... bit 0 = a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : input_debouncer
// Purpose  : 2-flop synchronizer plus per-bit stability counter.
// Revision : 1.0
// ============================================================================
module input_debouncer #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o
);

  localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             stable_q;
    logic             stable_d;

    // Accept on the last of DEBOUNCE_CYCLES consecutive differing cycles.
    always_comb begin
      cnt_d    = cnt_q;
      stable_d = stable_q;
      if (sync2_q[b] == stable_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q[b];
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        cnt_q    <= '0;
        stable_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        stable_q <= stable_d;
      end
    end

    assign stable_o[b] = stable_q;
  end

endmodule
`default_nettype wire

// File: rtl/mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmio_responder
// Purpose  : Load/store responder for the 0xF000_0000 board I/O window.
// Revision : 1.0
// ============================================================================
module mmio_responder #(
  parameter int                 DBITS           = 32,
  parameter int                 DEBOUNCE_CYCLES = 250000,
  parameter logic [DBITS-1:0]   ADDR_HEX        = io_pkg::ADDR_HEX,
  parameter logic [DBITS-1:0]   ADDR_LEDR       = io_pkg::ADDR_LEDR,
  parameter logic [DBITS-1:0]   ADDR_LEDG       = io_pkg::ADDR_LEDG,
  parameter logic [DBITS-1:0]   ADDR_KEY        = io_pkg::ADDR_KEY,
  parameter logic [DBITS-1:0]   ADDR_SW         = io_pkg::ADDR_SW,
  parameter logic [DBITS-1:0]   ADDR_KEYEDGE    = io_pkg::ADDR_KEYEDGE
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [DBITS-1:0] addr,
  input  logic             wrtEn,
  input  logic             rdEn,
  input  logic [DBITS-1:0] wrtData,
  output logic [DBITS-1:0] rdData,
  output logic             ioSel,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  output logic [6:0]       HEX0,
  output logic [6:0]       HEX1,
  output logic [6:0]       HEX2,
  output logic [6:0]       HEX3,
  output logic [9:0]       LEDR,
  output logic [7:0]       LEDG
);

  import io_pkg::*;

  logic [15:0] hex_q,     hex_d;
  logic [9:0]  ledr_q,    ledr_d;
  logic [7:0]  ledg_q,    ledg_d;
  logic [3:0]  keyprev_q, keyedge_q, keyedge_d;
  logic [3:0]  key_stable;
  logic [9:0]  sw_stable;
  logic        edge_clr;

  assign ioSel    = (addr[DBITS-1 -: 4] == 4'hF);
  assign edge_clr = rdEn && ioSel && (addr == ADDR_KEYEDGE);

  // Buttons are inverted here so everything downstream is 1 = pressed.
  input_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_db (
    .clk_i    (clk),
    .rst_i    (reset),
    .raw_i    (~KEY),
    .stable_o (key_stable)
  );

  input_debouncer #(.WIDTH(10), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sw_db (
    .clk_i    (clk),
    .rst_i    (reset),
    .raw_i    (SW),
    .stable_o (sw_stable)
  );

  always_comb begin
    hex_d  = hex_q;
    ledr_d = ledr_q;
    ledg_d = ledg_q;
    if (wrtEn && ioSel) begin
      if (addr == ADDR_HEX)  hex_d  = wrtData[15:0];
      if (addr == ADDR_LEDR) ledr_d = wrtData[9:0];
      if (addr == ADDR_LEDG) ledg_d = wrtData[7:0];
    end
    // A new press in the clearing cycle survives the clear.
    keyedge_d = (edge_clr ? 4'b0 : keyedge_q) | (key_stable & ~keyprev_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q     <= '0;
      ledr_q    <= '0;
      ledg_q    <= '0;
      keyprev_q <= '0;
      keyedge_q <= '0;
    end else begin
      hex_q     <= hex_d;
      ledr_q    <= ledr_d;
      ledg_q    <= ledg_d;
      keyprev_q <= key_stable;
      keyedge_q <= keyedge_d;
    end
  end

  always_comb begin
    rdData = '0;
    if (ioSel) begin
      if      (addr == ADDR_HEX)     rdData[15:0] = hex_q;
      else if (addr == ADDR_LEDR)    rdData[9:0]  = ledr_q;
      else if (addr == ADDR_LEDG)    rdData[7:0]  = ledg_q;
      else if (addr == ADDR_KEY)     rdData[3:0]  = key_stable;
      else if (addr == ADDR_SW)      rdData[9:0]  = sw_stable;
      else if (addr == ADDR_KEYEDGE) rdData[3:0]  = keyedge_q;
    end
  end

  assign HEX0 = hex_to_seg(hex_q[3:0]);
  assign HEX1 = hex_to_seg(hex_q[7:4]);
  assign HEX2 = hex_to_seg(hex_q[11:8]);
  assign HEX3 = hex_to_seg(hex_q[15:12]);
  assign LEDR = ledr_q;
  assign LEDG = ledg_q;

endmodule
`default_nettype wire

// File: tb/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmio_responder
// Purpose  : Directed self-checking bench for mmio_responder, debounce of 4.
// Revision : 1.0
// ============================================================================
module tb_mmio_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        wrtEn;
  logic        rdEn;
  logic [31:0] wrtData;
  logic [31:0] rdData;
  logic        ioSel;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [6:0]  HEX0, HEX1, HEX2, HEX3;
  logic [9:0]  LEDR;
  logic [7:0]  LEDG;

  int checks = 0;
  int errors = 0;

  mmio_responder #(.DBITS(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .addr    (addr),
    .wrtEn   (wrtEn),
    .rdEn    (rdEn),
    .wrtData (wrtData),
    .rdData  (rdData),
    .ioSel   (ioSel),
    .KEY     (KEY),
    .SW      (SW),
    .HEX0    (HEX0),
    .HEX1    (HEX1),
    .HEX2    (HEX2),
    .HEX3    (HEX3),
    .LEDR    (LEDR),
    .LEDG    (LEDG)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr    = a;
    wrtData = d;
    wrtEn   = 1'b1;
    tick();
    wrtEn   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; addr = '0; wrtEn = 1'b0; rdEn = 1'b0; wrtData = '0;
    KEY = 4'hF; SW = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_hex0", 32'(HEX0), 32'h40);
    chk("rst_hex1", 32'(HEX1), 32'h40);
    chk("rst_hex2", 32'(HEX2), 32'h40);
    chk("rst_hex3", 32'(HEX3), 32'h40);
    chk("rst_ledr", 32'(LEDR), 32'h0);
    chk("rst_ledg", 32'(LEDG), 32'h0);
    addr = 32'hF000_0018; #1;
    chk("rst_keyedge", rdData, 32'h0);
    chk("iosel_hi", 32'(ioSel), 32'h1);

    // HEX store and readback
    wr(32'hF000_0000, 32'h0000_BEEF);
    chk("hex0_F", 32'(HEX0), 32'h0E);
    chk("hex1_E", 32'(HEX1), 32'h06);
    chk("hex2_E", 32'(HEX2), 32'h06);
    chk("hex3_b", 32'(HEX3), 32'h03);
    chk("hex_rd", rdData, 32'h0000_BEEF);

    // Store outside the window must not land on HEX
    wr(32'h0000_0000, 32'h0000_1234);
    chk("nowin_hex0", 32'(HEX0), 32'h0E);
    chk("nowin_rd", rdData, 32'h0);
    chk("iosel_lo", 32'(ioSel), 32'h0);

    // LEDR store truncates to 10 bits
    wr(32'hF000_0004, 32'hFFFF_FFFF);
    chk("ledr_pin", 32'(LEDR), 32'h3FF);
    chk("ledr_rd", rdData, 32'h3FF);

    // Same-cycle read and write of LEDG returns the old value
    addr = 32'hF000_0008; wrtData = 32'h0000_01A5; wrtEn = 1'b1; rdEn = 1'b1; #1;
    chk("ledg_rdw_old", rdData, 32'h0);
    tick();
    wrtEn = 1'b0; rdEn = 1'b0;
    chk("ledg_pin", 32'(LEDG), 32'hA5);
    chk("ledg_rd", rdData, 32'hA5);

    // Stores to read-only registers are ignored
    wr(32'hF000_0014, 32'h0000_03FF);
    chk("sw_ro", rdData, 32'h0);
    wr(32'hF000_0018, 32'h0000_000F);
    chk("keyedge_ro", rdData, 32'h0);

    // SW debounce: 2 sync edges + 4 stable edges
    addr = 32'hF000_0014;
    SW = 10'h155;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("sw_settle_e%0d", k), rdData, (k >= 6) ? 32'h155 : 32'h0);
    end

    // 3-cycle glitch on SW[0] must be filtered
    SW = 10'h154;
    repeat (3) tick();
    SW = 10'h155;
    chk("sw_glitch_mid", rdData, 32'h155);
    repeat (8) tick();
    chk("sw_glitch_end", rdData, 32'h155);

    // Reset during a pending change discards it and restarts the count
    SW = 10'h0AA;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("sw_rst_clear", rdData, 32'h0);
    chk("ledr_rst", 32'(LEDR), 32'h0);
    repeat (5) tick();
    chk("sw_rst_e5", rdData, 32'h0);
    tick();
    chk("sw_rst_e6", rdData, 32'h0AA);

    // KEY[2] press, sticky edge, clear-on-read
    addr = 32'hF000_0010;
    KEY = 4'b1011;
    repeat (5) tick();
    chk("key_e5", rdData, 32'h0);
    tick();
    chk("key_e6", rdData, 32'h4);
    addr = 32'hF000_0018; #1;
    chk("keyedge_not_yet", rdData, 32'h0);
    tick();
    chk("keyedge_set", rdData, 32'h4);
    rdEn = 1'b1; #1;
    chk("keyedge_rd", rdData, 32'h4);
    tick();
    rdEn = 1'b0;
    chk("keyedge_cleared", rdData, 32'h0);

    // Release then re-press sets the bit again
    KEY = 4'hF;
    repeat (6) tick();
    addr = 32'hF000_0010; #1;
    chk("key_released", rdData, 32'h0);
    chk("keyedge_no_release_edge", 32'(dut.keyedge_q), 32'h0);
    KEY = 4'b1011;
    repeat (7) tick();
    addr = 32'hF000_0018; #1;
    chk("keyedge_repress", rdData, 32'h4);

    // Clear in the same cycle as a KEY[0] rise: bit 0 survives, bit 2 clears
    KEY = 4'b1010;
    repeat (6) tick();
    addr = 32'hF000_0010; #1;
    chk("key_both", rdData, 32'h5);
    addr = 32'hF000_0018; rdEn = 1'b1; #1;
    chk("keyedge_pre_clr", rdData, 32'h4);
    tick();
    rdEn = 1'b0;
    chk("keyedge_set_wins", rdData, 32'h1);

    // Unmapped addresses
    addr = 32'hF000_0020; #1;
    chk("unmapped_io", rdData, 32'h0);
    chk("unmapped_io_sel", 32'(ioSel), 32'h1);
    addr = 32'h0000_1000; rdEn = 1'b1; #1;
    chk("unmapped_mem", rdData, 32'h0);
    chk("unmapped_mem_sel", 32'(ioSel), 32'h0);
    rdEn = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
